// File: rtl/dtmf_pkg.sv
// Shared types and constants for the DTMF dial sequencer.
// Holds the FSM state encoding, the entry-format bit positions and the key codes.
package dtmf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_TONE,
        S_GAP,
        S_FIN
    } state_t;

    localparam int END_MARK_BIT = 15;
    localparam int DIGIT_W      = 4;

    localparam logic [DIGIT_W-1:0] KEY_STAR = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_HASH = 4'hB;

endpackage

// File: rtl/dtmf_dwell_counter.sv
// Loadable down-counter with a terminal-count flag.
// The sequencer shares one instance between the tone and gap phases.
module dtmf_dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dtmf_dial_sequencer.sv
// Walks the dial-number RAM from BASE_ADDR and plays each stored digit as a
// timed DTMF tone followed by a silent gap.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for start
//   FETCH   | RAM read issued at BASE_ADDR+index
//   CHECK   | read data valid; end marker or latch digit and load tone
//   TONE    | tone generator enabled for TONE_CYCLES
//   GAP     | silence for GAP_CYCLES, then next entry or finish
//   FIN     | one-cycle done pulse, busy already low
module dtmf_dial_sequencer
    import dtmf_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int BASE_ADDR   = 0,
    parameter int MAX_DIGITS  = 12,
    parameter int TONE_CYCLES = 4000,
    parameter int GAP_CYCLES  = 2000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               ram_en,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_di,
    input  logic [DATA_W-1:0]  ram_do,
    output logic               tone_en,
    output logic [DIGIT_W-1:0] tone_digit,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  digit_count
);

    localparam int DWELL_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(DWELL_MAX) + 1;

    localparam logic [CNT_W-1:0]  TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   MAX_IDX   = (ADDR_W + 1)'(MAX_DIGITS);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   index, index_nx;
    logic                cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0]    cnt_val;
    logic                count_clr, count_inc, digit_ld;
    logic [DATA_W-1:0]   ram_do_unused;

    // Bits [14:4] of an entry carry no meaning for dialing.
    assign ram_do_unused = ram_do;

    assign ram_we = 1'b0;
    assign ram_di = '0;

    dtmf_dwell_counter #(.W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        index_nx  = index;
        cnt_load  = 1'b0;
        cnt_val   = TONE_LOAD;
        cnt_dec   = 1'b0;
        count_clr = 1'b0;
        count_inc = 1'b0;
        digit_ld  = 1'b0;
        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nx  = S_FETCH;
                        index_nx  = '0;
                        count_clr = 1'b1;
                    end
                end
                S_FETCH: state_nx = S_CHECK;
                S_CHECK: begin
                    if (ram_do[END_MARK_BIT]) begin
                        state_nx = S_FIN;
                    end else begin
                        digit_ld = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = TONE_LOAD;
                        state_nx = S_TONE;
                    end
                end
                S_TONE: begin
                    if (cnt_tc) begin
                        count_inc = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_val   = GAP_LOAD;
                        state_nx  = S_GAP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_tc) begin
                        // Stop before the address could run past the last allowed entry.
                        if (({1'b0, index} + 1'b1) == MAX_IDX) begin
                            state_nx = S_FIN;
                        end else begin
                            index_nx = index + 1'b1;
                            state_nx = S_FETCH;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index       <= '0;
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            tone_en     <= 1'b0;
            tone_digit  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            digit_count <= '0;
        end else begin
            index   <= index_nx;
            ram_en  <= (state_nx == S_FETCH);
            tone_en <= (state_nx == S_TONE);
            busy    <= (state_nx != S_IDLE) && (state_nx != S_FIN);
            done    <= (state_nx == S_FIN);
            if (state_nx == S_FETCH) begin
                ram_addr <= BASE + index_nx;
            end
            if (digit_ld) begin
                tone_digit <= ram_do[DIGIT_W-1:0];
            end
            if (count_clr) begin
                digit_count <= '0;
            end else if (count_inc) begin
                digit_count <= digit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dtmf_dial_sequencer.sv
// Directed bench for dtmf_dial_sequencer with short tone/gap timing.
// Cycle n is the clock period that follows the n-th edge after the start edge (edge 0).
module tb_dtmf_dial_sequencer;
    import dtmf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        ram_en;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_do = '0;
    logic        tone_en;
    logic [3:0]  tone_digit;
    logic        busy;
    logic        done;
    logic [5:0]  digit_count;

    logic [15:0] mem [64];

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;
    int t0     = 0;
    int cyc;
    int tone_cyc [$];
    logic [3:0] tone_dig [$];
    logic [5:0] addr_log [$];
    int done_cnt = 0;
    int done_cyc = 0;

    dtmf_dial_sequencer #(
        .ADDR_W(6), .DATA_W(16), .BASE_ADDR(0), .MAX_DIGITS(12),
        .TONE_CYCLES(4), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_do(ram_do), .tone_en(tone_en), .tone_digit(tone_digit),
        .busy(busy), .done(done), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (ram_en) ram_do <= mem[ram_addr];
    end

    always @(negedge clk) begin
        cyc = ecnt - t0 + 1;
        if (tone_en) begin
            tone_cyc.push_back(cyc);
            tone_dig.push_back(tone_digit);
        end
        if (ram_en) addr_log.push_back(ram_addr);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        tone_cyc.delete();
        tone_dig.delete();
        addr_log.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t0 = ecnt;
        clear_logs();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic load_short();
        foreach (mem[i]) mem[i] = 16'h8000;
        mem[0] = 16'h0001;
        mem[1] = 16'h0002;
        mem[2] = 16'h0003;
        mem[3] = 16'h8000;
    endtask

    initial begin
        int bad;
        int max_a;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        load_short();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_tone_en", 32'(tone_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(digit_count), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_we_di", 32'({ram_we, ram_di}), 32'd0);
        rst_n = 1'b1;

        // Three digits then end marker
        kick();
        wait_idle("t1_timeout", 200);
        check("t1_addr_n", 32'(addr_log.size()), 32'd4);
        check("t1_addr0", 32'(addr_log[0]), 32'd0);
        check("t1_addr3", 32'(addr_log[3]), 32'd3);
        check("t1_tone_n", 32'(tone_cyc.size()), 32'd12);
        check("t1_tone_first", 32'(tone_cyc[0]), 32'd3);
        check("t1_tone_d1_last", 32'(tone_cyc[3]), 32'd6);
        check("t1_tone_d2_first", 32'(tone_cyc[4]), 32'd11);
        check("t1_tone_d3_first", 32'(tone_cyc[8]), 32'd19);
        check("t1_tone_last", 32'(tone_cyc[11]), 32'd22);
        check("t1_dig1", 32'(tone_dig[0]), 32'd1);
        check("t1_dig2", 32'(tone_dig[4]), 32'd2);
        check("t1_dig3", 32'(tone_dig[8]), 32'd3);
        check("t1_done_n", 32'(done_cnt), 32'd1);
        check("t1_done_cyc", 32'(done_cyc), 32'd27);
        check("t1_count", 32'(digit_count), 32'd3);
        check("t1_digit_hold", 32'(tone_digit), 32'd3);

        // No end marker: MAX_DIGITS stops the run
        foreach (mem[i]) mem[i] = {4'h7, 8'hFF, KEY_STAR};
        kick();
        wait_idle("t2_timeout", 400);
        bad = 0;
        foreach (tone_dig[i]) if (tone_dig[i] !== KEY_STAR) bad++;
        max_a = 0;
        foreach (addr_log[i]) if (int'(addr_log[i]) > max_a) max_a = int'(addr_log[i]);
        check("t2_tone_n", 32'(tone_cyc.size()), 32'd48);
        check("t2_bad_digits", 32'(bad), 32'd0);
        check("t2_addr_n", 32'(addr_log.size()), 32'd12);
        check("t2_max_addr", 32'(max_a), 32'd11);
        check("t2_done_n", 32'(done_cnt), 32'd1);
        check("t2_done_cyc", 32'(done_cyc), 32'd97);
        check("t2_count", 32'(digit_count), 32'd12);

        // End marker in the first entry
        mem[0] = 16'h8000;
        mem[1] = {12'h000, KEY_HASH};
        kick();
        wait_idle("t3_timeout", 100);
        check("t3_ram_en_n", 32'(addr_log.size()), 32'd1);
        check("t3_tone_n", 32'(tone_cyc.size()), 32'd0);
        check("t3_done_n", 32'(done_cnt), 32'd1);
        check("t3_done_cyc", 32'(done_cyc), 32'd3);
        check("t3_count", 32'(digit_count), 32'd0);

        // Abort on the second cycle of the second tone
        load_short();
        kick();
        repeat (11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("t4_tone_off", 32'(tone_en), 32'd0);
        check("t4_busy_off", 32'(busy), 32'd0);
        check("t4_ram_en_off", 32'(ram_en), 32'd0);
        repeat (6) @(negedge clk);
        check("t4_done_n", 32'(done_cnt), 32'd0);
        check("t4_count", 32'(digit_count), 32'd1);
        check("t4_tone_n", 32'(tone_cyc.size()), 32'd6);
        check("t4_tone_last", 32'(tone_cyc[5]), 32'd12);
        kick();
        wait_idle("t4_restart_timeout", 200);
        check("t4_restart_addr0", 32'(addr_log[0]), 32'd0);
        check("t4_restart_done_cyc", 32'(done_cyc), 32'd27);
        check("t4_restart_count", 32'(digit_count), 32'd3);

        // start re-pulsed while busy is ignored
        kick();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("t5_timeout", 200);
        check("t5_addr_n", 32'(addr_log.size()), 32'd4);
        check("t5_tone_n", 32'(tone_cyc.size()), 32'd12);
        check("t5_tone_first", 32'(tone_cyc[0]), 32'd3);
        check("t5_tone_last", 32'(tone_cyc[11]), 32'd22);
        check("t5_done_cyc", 32'(done_cyc), 32'd27);

        // Asynchronous reset in the first gap
        kick();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_gap_check", 32'(tone_cyc.size()), 32'd4);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_count", 32'(digit_count), 32'd0);
        check("t6_digit", 32'(tone_digit), 32'd0);
        check("t6_ram", 32'({ram_en, ram_addr}), 32'd0);
        check("t6_tone_done", 32'({tone_en, done}), 32'd0);
        #4 rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_fetch", 32'(addr_log.size()), 32'd0);
        kick();
        wait_idle("t6_restart_timeout", 200);
        check("t6_restart_count", 32'(digit_count), 32'd3);
        check("t6_restart_done_n", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
